// File: rtl/demux_1to32_collector.sv
// demux_1to32_collector: scatters a tagged serial bit stream into a WIDTH-bit word
// and hands the word off on a valid/ready interface once every position has been
// written, or earlier on flush.
// Optional feature macro: DEMUX_PARITY_EN adds a registered even-parity output word_par.

// One bit position of the word: data bit, written flag, and its next-state value.
module demux_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic wr,
  input  logic bit_in,
  output logic data,
  output logic mask,
  output logic data_nxt
);

  logic mask_nxt;

  // Clear wins. A clear only happens in FULL, and writes only happen in COLLECT.
  always_comb begin
    data_nxt = data;
    mask_nxt = mask;
    if (clr) begin
      data_nxt = 1'b0;
      mask_nxt = 1'b0;
    end else if (wr) begin
      data_nxt = bit_in;
      mask_nxt = 1'b1;
    end
  end

  // Lane storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= 1'b0;
      mask <= 1'b0;
    end else begin
      data <= data_nxt;
      mask <= mask_nxt;
    end
  end

endmodule

module demux_1to32_collector #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic [IDX_W-1:0] bit_sel,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] word_out,
  output logic [WIDTH-1:0] word_mask,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             dup_err
`ifdef DEMUX_PARITY_EN
  ,output logic            word_par
`endif
);

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic             accept;
  logic             clr;
  logic             go_full;
  logic [WIDTH-1:0] sel_oh;
  logic [WIDTH-1:0] mask_post;
  logic [WIDTH-1:0] word_nxt;

  // Accept, write select and the post-write mask used to decide COLLECT->FULL.
  always_comb begin
    accept    = bit_valid & bit_ready;
    sel_oh    = accept ? (WIDTH'(1) << bit_sel) : '0;
    mask_post = word_mask | sel_oh;
    go_full   = (&mask_post) | (flush & (|mask_post));
    clr       = (state == FULL) & word_ready;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      demux_lane u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .wr       (sel_oh[gi]),
        .bit_in   (bit_in),
        .data     (word_out[gi]),
        .mask     (word_mask[gi]),
        .data_nxt (word_nxt[gi])
      );
    end
  endgenerate

  // Handshake FSM with registered bit_ready / word_valid / dup_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      bit_ready  <= 1'b1;
      word_valid <= 1'b0;
      dup_err    <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          dup_err <= accept & word_mask[bit_sel];
          if (go_full) begin
            state      <= FULL;
            bit_ready  <= 1'b0;
            word_valid <= 1'b1;
          end
        end
        default: begin
          dup_err <= 1'b0;
          if (word_ready) begin
            state      <= COLLECT;
            bit_ready  <= 1'b1;
            word_valid <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef DEMUX_PARITY_EN
  // Parity tracks the next word value, so it is in step with word_out every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_par <= 1'b0;
    else        word_par <= ^word_nxt;
  end
`else
  logic unused_nxt;
  assign unused_nxt = ^word_nxt;
`endif

endmodule

// File: tb/tb_demux_1to32_collector.sv
// Directed bench for demux_1to32_collector: a vector table plus hand-written
// multi-cycle sequences (full word, gapped reverse order, FULL hold, reset mid-word).
module tb_demux_1to32_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic [4:0]  bit_sel = '0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic        flush = 1'b0;
  logic [31:0] word_out;
  logic [31:0] word_mask;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        dup_err;
`ifdef DEMUX_PARITY_EN
  logic        word_par;
`endif

  int checks = 0;
  int failures = 0;

  demux_1to32_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_sel    (bit_sel),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .flush      (flush),
    .word_out   (word_out),
    .word_mask  (word_mask),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .dup_err    (dup_err)
`ifdef DEMUX_PARITY_EN
    ,.word_par  (word_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  sel;
    logic        b;
    logic        fl;
    logic        wr;
    logic [31:0] ew;
    logic [31:0] em;
    logic        ewv;
    logic        ebr;
    logic        edup;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic v, logic [4:0] sel, logic b, logic fl, logic wr,
                              logic [31:0] ew, logic [31:0] em,
                              logic ewv, logic ebr, logic edup);
    vec_t t;
    t.v = v; t.sel = sel; t.b = b; t.fl = fl; t.wr = wr;
    t.ew = ew; t.em = em; t.ewv = ewv; t.ebr = ebr; t.edup = edup;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [4:0] sel, logic b, logic fl, logic wr);
    bit_valid = v; bit_sel = sel; bit_in = b; flush = fl; word_ready = wr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(string name);
    chk({name, " word_out"},   word_out,   32'h0);
    chk({name, " word_mask"},  word_mask,  32'h0);
    chk({name, " word_valid"}, {31'h0, word_valid}, 32'h0);
    chk({name, " bit_ready"},  {31'h0, bit_ready},  32'h1);
    chk({name, " dup_err"},    {31'h0, dup_err},    32'h0);
  endtask

  localparam logic [31:0] PAT = 32'hA5A5F00F;

  initial begin
    logic [31:0] pat;
    logic [31:0] held;
    int sent;
    int dups;
    int cyc;
    int bad;
    pat = PAT;

    // vector table: {valid, sel, bit, flush, word_ready} -> {word, mask, wv, br, dup}
    tbl[0]  = mk(0, 5'd0, 0, 1, 0, 32'h0,  32'h0,  0, 1, 0); // flush on empty: ignored
    tbl[1]  = mk(0, 5'd0, 0, 0, 1, 32'h0,  32'h0,  0, 1, 0); // word_ready in COLLECT
    tbl[2]  = mk(1, 5'd0, 1, 0, 0, 32'h1,  32'h1,  0, 1, 0);
    tbl[3]  = mk(1, 5'd1, 0, 0, 0, 32'h1,  32'h3,  0, 1, 0);
    tbl[4]  = mk(1, 5'd2, 1, 0, 0, 32'h5,  32'h7,  0, 1, 0);
    tbl[5]  = mk(0, 5'd0, 0, 1, 0, 32'h5,  32'h7,  1, 0, 0); // flush -> FULL
    tbl[6]  = mk(1, 5'd5, 1, 1, 0, 32'h5,  32'h7,  1, 0, 0); // bit and flush ignored in FULL
    tbl[7]  = mk(0, 5'd0, 0, 0, 1, 32'h0,  32'h0,  0, 1, 0); // handoff
    tbl[8]  = mk(1, 5'd3, 1, 0, 0, 32'h8,  32'h8,  0, 1, 0);
    tbl[9]  = mk(1, 5'd3, 0, 0, 0, 32'h0,  32'h8,  0, 1, 1); // duplicate overwrites
    tbl[10] = mk(0, 5'd0, 0, 0, 0, 32'h0,  32'h8,  0, 1, 0); // dup pulse is 1 cycle
    tbl[11] = mk(1, 5'd4, 1, 1, 0, 32'h10, 32'h18, 1, 0, 0); // flush + accept same cycle
    tbl[12] = mk(0, 5'd0, 0, 0, 1, 32'h0,  32'h0,  0, 1, 0);

    // reset state
    drive(1, 5'd7, 1, 1, 1);
    step(); step();
    chk_idle("reset");
    drive(0, 5'd0, 0, 0, 0);
    rst_n = 1'b1;
    step();

    // table-driven vectors
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].b, tbl[i].fl, tbl[i].wr);
      step();
      chk($sformatf("vec%0d word_out", i),   word_out,  tbl[i].ew);
      chk($sformatf("vec%0d word_mask", i),  word_mask, tbl[i].em);
      chk($sformatf("vec%0d word_valid", i), {31'h0, word_valid}, {31'h0, tbl[i].ewv});
      chk($sformatf("vec%0d bit_ready", i),  {31'h0, bit_ready},  {31'h0, tbl[i].ebr});
      chk($sformatf("vec%0d dup_err", i),    {31'h0, dup_err},    {31'h0, tbl[i].edup});
    end
    drive(0, 5'd0, 0, 0, 0);

    // full word in order, valid every cycle
    for (int i = 0; i < 32; i++) begin
      drive(1, 5'(i), pat[i], 0, 0);
      step();
      if (i == 30) chk("seq1 not full after 31", {31'h0, word_valid}, 32'h0);
    end
    drive(0, 5'd0, 0, 0, 0);
    chk("seq1 word_valid", {31'h0, word_valid}, 32'h1);
    chk("seq1 word_out",   word_out,  PAT);
    chk("seq1 word_mask",  word_mask, 32'hFFFFFFFF);
    chk("seq1 bit_ready",  {31'h0, bit_ready}, 32'h0);

    // FULL hold: word_ready low, bit_valid high with changing data
    held = word_out;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 5'(i), ~pat[i], 1, 0);
      step();
      if (word_out !== held || word_mask !== 32'hFFFFFFFF || word_valid !== 1'b1 ||
          bit_ready !== 1'b0) bad++;
    end
    chk("seq5 hold unstable cycles", 32'(bad), 32'h0);
    drive(0, 5'd0, 0, 0, 1);
    step();
    drive(0, 5'd0, 0, 0, 0);
    chk("seq5 bit_ready after release", {31'h0, bit_ready}, 32'h1);
    chk("seq5 word_mask after release", word_mask, 32'h0);
    chk("seq5 word_valid after release", {31'h0, word_valid}, 32'h0);

    // reverse order with random gaps
    sent = 0; dups = 0; cyc = 0;
    while (sent < 32 && cyc < 400) begin
      if ($urandom_range(0, 2) != 0) begin
        drive(1, 5'(31 - sent), pat[31 - sent], 0, 0);
        sent++;
      end else begin
        drive(0, 5'd0, 0, 0, 0);
      end
      step();
      cyc++;
      if (dup_err) dups++;
    end
    drive(0, 5'd0, 0, 0, 0);
    chk("seq2 all bits sent", 32'(sent), 32'd32);
    chk("seq2 dup pulses", 32'(dups), 32'h0);
    chk("seq2 word_valid", {31'h0, word_valid}, 32'h1);
    chk("seq2 word_out", word_out, PAT);
    drive(0, 5'd0, 0, 0, 1);
    step();
    drive(0, 5'd0, 0, 0, 0);

    // reset after 16 accepts, then a clean word
    for (int i = 0; i < 16; i++) begin
      drive(1, 5'(i), 1'b1, 0, 0);
      step();
    end
    chk("seq6 mask before reset", word_mask, 32'h0000FFFF);
    drive(0, 5'd0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_idle("seq6 async reset");
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(i), 1'b1, (i == 2), 0);
      step();
    end
    drive(0, 5'd0, 0, 0, 0);
    chk("seq6 word_valid", {31'h0, word_valid}, 32'h1);
    chk("seq6 word_out",   word_out,  32'h7);
    chk("seq6 word_mask",  word_mask, 32'h7);
`ifdef DEMUX_PARITY_EN
    chk("seq6 word_par", {31'h0, word_par}, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
